// File: rtl/conv_neuron_update_if.sv
// Request/result bus of the convolutional neuron update pipeline.
// The master side issues membrane update requests and consumes write-backs;
// the slave side is the update pipeline itself.
interface conv_neuron_update_if #(
    parameter int unsigned OUT_CHANNELS           = 2,
    parameter int unsigned BITS_PER_NEURON        = 9,
    parameter int unsigned BITS_PER_KERNEL_WEIGHT = 6,
    parameter int unsigned ADDR_WIDTH             = 6
);
    localparam int unsigned FM_W = OUT_CHANNELS * BITS_PER_NEURON;
    localparam int unsigned WT_W = OUT_CHANNELS * BITS_PER_KERNEL_WEIGHT;

    // Request side
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_mode;
    logic [ADDR_WIDTH-1:0]      in_addr;
    logic [FM_W-1:0]            in_fm;
    logic [WT_W-1:0]            in_weights;
    logic [BITS_PER_NEURON-1:0] leak;
    logic [BITS_PER_NEURON-1:0] threshold;

    // Write-back side
    logic                       out_valid;
    logic                       out_ready;
    logic [ADDR_WIDTH-1:0]      out_addr;
    logic [FM_W-1:0]            out_fm;
    logic [OUT_CHANNELS-1:0]    out_spikes;

    modport master (
        output in_valid, in_mode, in_addr, in_fm, in_weights, leak, threshold, out_ready,
        input  in_ready, out_valid, out_addr, out_fm, out_spikes
    );

    modport slave (
        input  in_valid, in_mode, in_addr, in_fm, in_weights, leak, threshold, out_ready,
        output in_ready, out_valid, out_addr, out_fm, out_spikes
    );
endinterface

// File: rtl/conv_neuron_update.sv
// Two-stage membrane update pipeline for one feature-map word.
// S1 captures the request (with forwarding of in-flight results), S2 computes
// ACCUMULATE (saturating add of kernel weights) or LEAK_FIRE (leak toward zero,
// threshold, reset-to-zero) per channel and holds the write-back result.
module conv_neuron_update #(
    parameter int unsigned OUT_CHANNELS           = 2,
    parameter int unsigned BITS_PER_NEURON        = 9,
    parameter int unsigned BITS_PER_KERNEL_WEIGHT = 6,
    parameter int unsigned ADDR_WIDTH             = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_neuron_update_if.slave     bus
);
    localparam int unsigned C    = OUT_CHANNELS;
    localparam int unsigned N    = BITS_PER_NEURON;
    localparam int unsigned W    = BITS_PER_KERNEL_WEIGHT;
    localparam int unsigned FM_W = C * N;
    localparam int unsigned WT_W = C * W;

    // Stage 1 request registers
    logic                  s1_valid;
    logic                  s1_mode;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [FM_W-1:0]       s1_fm;
    logic [WT_W-1:0]       s1_weights;
    logic [N-1:0]          s1_leak;
    logic [N-1:0]          s1_threshold;

    // Stage 2 result registers (drive the write-back bus directly)
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [FM_W-1:0]       s2_fm;
    logic [C-1:0]          s2_spikes;

    // Pipeline control
    logic                  s2_free_c;
    logic                  s1_adv_c;
    logic                  in_accept_c;
    logic [FM_W-1:0]       cap_fm_c;
    logic [FM_W-1:0]       op_fm_c;
    logic [FM_W-1:0]       res_fm_c;
    logic [C-1:0]          res_spikes_c;
    logic signed [N-1:0]   thr_c;
    logic signed [N+1:0]   leak_x_c;

    // S2 can take a new result when empty or when its result leaves this cycle
    assign s2_free_c   = !s2_valid || bus.out_ready;
    assign s1_adv_c    = s1_valid && s2_free_c;
    assign bus.in_ready = !rst && (!s1_valid || s2_free_c);
    assign in_accept_c = bus.in_valid && bus.in_ready;

    // A result still held in S2 is newer than what memory returns for its address
    assign cap_fm_c = (s2_valid && (s2_addr == bus.in_addr)) ? s2_fm : bus.in_fm;

    // When S1 moves into S2, the result S2 is handing off is the freshest copy
    assign op_fm_c = (s2_valid && (s2_addr == s1_addr)) ? s2_fm : s1_fm;

    assign thr_c    = s1_threshold;
    assign leak_x_c = {2'b00, s1_leak};

    // Per-channel datapath; channels never interact
    for (genvar c = 0; c < C; c++) begin : g_ch
        logic signed [N-1:0] fm_c;
        logic signed [W-1:0] wt_c;
        logic signed [N:0]   sum_c;
        logic signed [N-1:0] acc_c;
        logic signed [N+1:0] fm_x_c;
        logic signed [N-1:0] v_c;
        logic                fire_c;

        assign fm_c = op_fm_c[c*N +: N];
        assign wt_c = s1_weights[c*W +: W];

        // Saturating add at one extra bit of headroom
        assign sum_c = $signed({fm_c[N-1], fm_c}) + $signed({{(N+1-W){wt_c[W-1]}}, wt_c});
        assign acc_c = (sum_c[N] == sum_c[N-1]) ? sum_c[N-1:0]
                     : (sum_c[N] ? $signed({1'b1, {(N-1){1'b0}}})
                                 : $signed({1'b0, {(N-1){1'b1}}}));

        // Leak moves the membrane toward zero without crossing it
        assign fm_x_c = {{2{fm_c[N-1]}}, fm_c};
        assign v_c = (fm_x_c > leak_x_c)  ? N'(fm_x_c - leak_x_c)
                   : (fm_x_c < -leak_x_c) ? N'(fm_x_c + leak_x_c)
                   : '0;
        assign fire_c = (v_c >= thr_c);

        assign res_fm_c[c*N +: N] = s1_mode ? (fire_c ? '0 : v_c) : acc_c;
        assign res_spikes_c[c]    = s1_mode && fire_c;
    end

    // S1 capture: load on accept, empty once handed to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_mode      <= 1'b0;
            s1_addr      <= '0;
            s1_fm        <= '0;
            s1_weights   <= '0;
            s1_leak      <= '0;
            s1_threshold <= '0;
        end else if (in_accept_c) begin
            s1_valid     <= 1'b1;
            s1_mode      <= bus.in_mode;
            s1_addr      <= bus.in_addr;
            s1_fm        <= cap_fm_c;
            s1_weights   <= bus.in_weights;
            s1_leak      <= bus.leak;
            s1_threshold <= bus.threshold;
        end else if (s1_adv_c) begin
            s1_valid     <= 1'b0;
        end
    end

    // S2 result register: load computed result, hold while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_addr   <= '0;
            s2_fm     <= '0;
            s2_spikes <= '0;
        end else if (s1_adv_c) begin
            s2_valid  <= 1'b1;
            s2_addr   <= s1_addr;
            s2_fm     <= res_fm_c;
            s2_spikes <= res_spikes_c;
        end else if (bus.out_ready) begin
            s2_valid  <= 1'b0;
        end
    end

    assign bus.out_valid  = s2_valid;
    assign bus.out_addr   = s2_addr;
    assign bus.out_fm     = s2_fm;
    assign bus.out_spikes = s2_spikes;
endmodule

// File: tb/tb_conv_neuron_update.sv
// Scoreboard bench for conv_neuron_update: a behavioural feature-map memory
// feeds in_fm and absorbs write-backs; expected results come from an
// architectural model updated in request order.
module tb_conv_neuron_update;
    localparam int unsigned C    = 2;
    localparam int unsigned N    = 9;
    localparam int unsigned W    = 6;
    localparam int unsigned AW   = 6;
    localparam int unsigned FM_W = C * N;
    localparam int unsigned WT_W = C * W;
    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [FM_W-1:0] fm;
        logic [C-1:0]    spk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv_neuron_update_if #(.OUT_CHANNELS(C), .BITS_PER_NEURON(N),
                            .BITS_PER_KERNEL_WEIGHT(W), .ADDR_WIDTH(AW)) bus ();

    conv_neuron_update #(.OUT_CHANNELS(C), .BITS_PER_NEURON(N),
                         .BITS_PER_KERNEL_WEIGHT(W), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];
    logic [FM_W-1:0] model [0:DEPTH-1];
    logic [FM_W-1:0] mem   [0:DEPTH-1];
    logic            pl_en;
    logic [AW-1:0]   pl_addr;
    logic [FM_W-1:0] pl_data;

    // Feature-map memory: preload port plus write-back of transferred results
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (!rst && bus.out_valid && bus.out_ready) mem[bus.out_addr] <= bus.out_fm;
    end
    assign bus.in_fm = mem[bus.in_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FM_W-1:0] pack_fm(input int a, input int b);
        return {N'(b), N'(a)};
    endfunction

    function automatic logic [WT_W-1:0] pack_w(input int a, input int b);
        return {W'(b), W'(a)};
    endfunction

    function automatic int sval(input logic [31:0] v, input int bits);
        int r;
        r = int'(v & ((32'd1 << bits) - 1));
        if (v[bits-1]) r = r - (1 << bits);
        return r;
    endfunction

    // Architectural reference for one operation
    function automatic exp_t model_op(input logic mode, input logic [AW-1:0] addr,
                                      input logic [FM_W-1:0] fm, input logic [WT_W-1:0] wts,
                                      input logic [N-1:0] lk, input logic [N-1:0] thr);
        exp_t e;
        int f, w, v, l, t;
        e.addr = addr;
        e.fm   = '0;
        e.spk  = '0;
        l = int'(lk);
        t = sval(32'(thr), N);
        for (int c = 0; c < C; c++) begin
            f = sval(32'(fm[c*N +: N]), N);
            w = sval(32'(wts[c*W +: W]), W);
            if (!mode) begin
                v = f + w;
                if (v > (1 << (N-1)) - 1) v = (1 << (N-1)) - 1;
                if (v < -(1 << (N-1)))    v = -(1 << (N-1));
            end else begin
                if (f > l)       v = f - l;
                else if (f < -l) v = f + l;
                else             v = 0;
                if (v >= t) begin
                    e.spk[c] = 1'b1;
                    v = 0;
                end
            end
            e.fm[c*N +: N] = N'(v);
        end
        return e;
    endfunction

    // Output monitor: compare every valid output against the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'(bus.out_valid), 64'd0);
            end else begin
                check("out_addr",   64'(bus.out_addr),   64'(q[0].addr));
                check("out_fm",     64'(bus.out_fm),     64'(q[0].fm));
                check("out_spikes", 64'(bus.out_spikes), 64'(q[0].spk));
                if (bus.out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic preload(input logic [AW-1:0] a, input logic [FM_W-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        model[a] = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    task automatic drive(input logic mode, input logic [AW-1:0] addr, input logic [WT_W-1:0] wts,
                         input logic [N-1:0] lk, input logic [N-1:0] thr);
        exp_t e;
        e = model_op(mode, addr, model[addr], wts, lk, thr);
        model[addr] = e.fm;
        q.push_back(e);
        bus.in_valid   = 1'b1;
        bus.in_mode    = mode;
        bus.in_addr    = addr;
        bus.in_weights = wts;
        bus.leak       = lk;
        bus.threshold  = thr;
    endtask

    // Wait for the held request to be accepted; relax releases backpressure
    task automatic wait_accept(input bit relax);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                check("accept_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (relax) bus.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic issue(input logic mode, input logic [AW-1:0] addr, input logic [WT_W-1:0] wts,
                         input logic [N-1:0] lk, input logic [N-1:0] thr, input bit relax);
        drive(mode, addr, wts, lk, thr);
        wait_accept(relax);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0; bus.in_mode = 1'b0; bus.in_addr = '0; bus.in_weights = '0;
        bus.leak = '0; bus.threshold = '0; bus.out_ready = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",   64'(bus.in_ready),   64'd0);
        check("rst_out_valid",  64'(bus.out_valid),  64'd0);
        check("rst_out_addr",   64'(bus.out_addr),   64'd0);
        check("rst_out_fm",     64'(bus.out_fm),     64'd0);
        check("rst_out_spikes", 64'(bus.out_spikes), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        for (int a = 0; a < int'(DEPTH); a++) preload(AW'(a), FM_W'($urandom));

        // ACCUMULATE with exact two-cycle latency
        preload(6'd1, pack_fm(100, -50));
        issue(1'b0, 6'd1, pack_w(20, -10), '0, '0, 1'b0);
        @(negedge clk);
        check("lat_s1_empty", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check("lat_s2_valid", 64'(bus.out_valid), 64'd1);
        check("acc_fm",       64'(bus.out_fm),    64'(pack_fm(120, -60)));
        check("acc_spikes",   64'(bus.out_spikes), 64'd0);
        drain();

        // Saturation at both rails
        preload(6'd2, pack_fm(250, -250));
        issue(1'b0, 6'd2, pack_w(31, -32), '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("sat_fm", 64'(bus.out_fm), 64'(pack_fm(255, -256)));
        drain();

        // LEAK_FIRE: below/above threshold, then small negative leaks to zero
        preload(6'd3, pack_fm(104, 106));
        preload(6'd4, pack_fm(-3, -200));
        issue(1'b1, 6'd3, '0, 9'd5, 9'd100, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("leak_fm",     64'(bus.out_fm),     64'(pack_fm(99, 0)));
        check("leak_spikes", 64'(bus.out_spikes), 64'(2'b10));
        drain();
        issue(1'b1, 6'd4, '0, 9'd5, 9'd100, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("leak_neg_fm", 64'(bus.out_fm), 64'(pack_fm(0, -195)));
        drain();

        // Read-after-write hazards on one address
        preload(6'd7, pack_fm(10, 10));
        issue(1'b0, 6'd7, pack_w(1, 2), '0, '0, 1'b0);
        issue(1'b0, 6'd7, pack_w(1, 2), '0, '0, 1'b0);
        @(negedge clk);
        check("haz_first",  64'(bus.out_fm), 64'(pack_fm(11, 12)));
        @(negedge clk);
        check("haz_second", 64'(bus.out_fm), 64'(pack_fm(12, 14)));
        drain();
        issue(1'b0, 6'd7, pack_w(1, 1), '0, '0, 1'b0);
        @(posedge clk); #1;
        issue(1'b0, 6'd7, pack_w(-1, -3), '0, '0, 1'b0);
        issue(1'b1, 6'd7, '0, 9'd2, 9'd200, 1'b0);
        drain();

        // Backpressure: two accepted, third held off while outputs stall
        bus.out_ready = 1'b0;
        issue(1'b0, 6'd10, pack_w(3, -4), '0, '0, 1'b0);
        issue(1'b1, 6'd11, '0, 9'd7, 9'd50, 1'b0);
        drive(1'b0, 6'd10, pack_w(5, 6), '0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(bus.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        wait_accept(1'b0);
        drain();

        // Reset with two requests in flight
        bus.out_ready = 1'b0;
        issue(1'b0, 6'd20, pack_w(1, 1), '0, '0, 1'b0);
        issue(1'b0, 6'd21, pack_w(2, 2), '0, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        for (int a = 0; a < int'(DEPTH); a++) model[a] = mem[a];
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_ready_after", 64'(bus.in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_no_result", 64'(bus.out_valid), 64'd0);
        end
        @(posedge clk); #1;

        // Random traffic on a few addresses with random backpressure
        for (int i = 0; i < 80; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            issue(1'($urandom_range(0, 1)), AW'(32 + $urandom_range(0, 3)), WT_W'($urandom),
                  N'($urandom_range(0, 60)), N'($urandom_range(1, 255)), 1'b1);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk); #1;
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
